// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised single-port data memory with per-byte write enables,
// a req/ready/rvalid handshake, 1-cycle registered reads and a clear sequencer
// that zeroes the whole array after reset or on a clr request.
//
// Optional build macro: OOR_ERR_EN
//   defined   -> err pulses one cycle after any accepted access with adr >= DEPTH
//   undefined -> err tied to 0, no range-error logic
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   req     in   access request, accepted when req && ready
//   WE      in   1 = write, 0 = read
//   adr     in   word address [ADDR_W]
//   WD      in   write data [DATA_W]
//   be      in   byte enables [DATA_W/8]
//   clr     in   request to re-zero the whole array
//   ready   out  accept strobe (combinational: IDLE && !clr)
//   rvalid  out  one-cycle read-data-valid pulse
//   Memout  out  registered read data [DATA_W]
//   err     out  out-of-range access pulse
module data_mem_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  WE,
    input  logic [ADDR_W-1:0]     adr,
    input  logic [DATA_W-1:0]     WD,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  clr,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     Memout,
    output logic                  err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   clr_cnt;
    logic [IDX_W-1:0]   clr_cnt_nxt;
    logic               accept_c;
    logic               in_range_c;
    logic [IDX_W-1:0]   idx_c;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Only addresses below DEPTH map onto the array; the index is truncated
    // and only used when in range.
    assign in_range_c = (32'(adr) < DEPTH);
    assign idx_c      = IDX_W'(adr);

    // Next-state and handshake decode
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready       = 1'b0;
        accept_c    = 1'b0;
        case (state)
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + IDX_W'(1);
                if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end
            end
            IDLE: begin
                // clr wins over a simultaneous request
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else begin
                    ready    = 1'b1;
                    accept_c = req;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // State, clear counter and read port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            rvalid  <= 1'b0;
            Memout  <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            rvalid  <= accept_c && !WE;
            if (accept_c && !WE) begin
                Memout <= in_range_c ? mem[idx_c] : '0;
            end
        end
    end

    // Array write port: clear sequencer or byte-masked store
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept_c && WE && in_range_c) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx_c][8*i +: 8] <= WD[8*i +: 8];
                end
            end
        end
    end

`ifdef OOR_ERR_EN
    // Range error flag, aligned with rvalid for reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= accept_c && !in_range_c;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (DEPTH=20 so out-of-range addresses exist).
module tb_data_mem_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 20;
`ifdef OOR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              WE = 1'b0;
    logic [ADDR_W-1:0] adr = '0;
    logic [DATA_W-1:0] WD = '0;
    logic [1:0]        be = '0;
    logic              clr = 1'b0;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] Memout;
    logic              err;

    data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .WE(WE), .adr(adr), .WD(WD),
        .be(be), .clr(clr), .ready(ready), .rvalid(rvalid), .Memout(Memout),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    endtask

    // Monitor: every output event must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1 || err === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'({rvalid, err}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid", 32'(rvalid), 32'(e.rd));
                    if (e.rd) chk("Memout", 32'(Memout), 32'(e.data));
                    chk("err", 32'(err), 32'(e.e));
                end
            end
        end
    end

    // One access; expected read data from the model unless use_exp overrides it
    task automatic access(input logic we, input logic [4:0] a, input logic [15:0] wd,
                          input logic [1:0] b, input logic use_exp, input logic [15:0] exp_d);
        logic acc;
        logic oor;
        exp_t e;
        @(negedge clk);
        req = 1'b1; WE = we; adr = a; WD = wd; be = b; clr = 1'b0;
        #1;
        acc = ready;
        chk("ready_idle", 32'(ready), 32'd1);
        @(posedge clk);
        if (acc) begin
            oor = (32'(a) >= DEPTH);
            if (we) begin
                if (!oor) begin
                    for (int i = 0; i < 2; i++)
                        if (b[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
                end else if (ERR_EN) begin
                    e.rd = 1'b0; e.data = 16'h0; e.e = 1'b1;
                    sb.push_back(e);
                end
            end else begin
                e.rd   = 1'b1;
                e.data = oor ? 16'h0000 : ref_mem[a];
                if (use_exp) e.data = exp_d;
                e.e    = oor && ERR_EN;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0; clr = 1'b0;
        end
    endtask

    // Count negedges with ready low until ready rises; expect exactly DEPTH
    task automatic check_clear_len(input string name, input logic memout_zero);
        int   zeros = 0;
        logic quiet = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (ready === 1'b1) break;
            zeros++;
            if (rvalid !== 1'b0 || (memout_zero && Memout !== 16'h0)) quiet = 1'b0;
            @(negedge clk);
        end
        chk({name, "_len"}, 32'(zeros), 32'(DEPTH));
        chk({name, "_quiet"}, 32'(quiet), 32'd1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; req = 1'b0; clr = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        zero_model();
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1; req = 1'b1; WE = 1'b0; adr = '0;
        #1;
        chk("ready_on_clr", 32'(ready), 32'd0);
        @(negedge clk);
        clr = 1'b0; req = 1'b0;
        zero_model();
        check_clear_len("clr", 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        zero_model();
        // Power-up reset held for 2 cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_Memout", 32'(Memout), 32'd0);
        check_clear_len("reset", 1'b1);

        // Every in-range entry reads back zero after the clear
        for (int a = 0; a < DEPTH; a++) access(1'b0, 5'(a), 16'h0, 2'b00, 1'b1, 16'h0000);

        // Basic write/read, back-to-back reads
        access(1'b1, 5'd0, 16'hA5A5, 2'b11, 1'b0, 16'h0);
        access(1'b1, 5'd1, 16'h5A5A, 2'b11, 1'b0, 16'h0);
        access(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 16'hA5A5);
        access(1'b0, 5'd1, 16'h0, 2'b00, 1'b1, 16'h5A5A);

        // Byte enables
        access(1'b1, 5'd2, 16'hFFFF, 2'b11, 1'b0, 16'h0);
        access(1'b1, 5'd2, 16'h1234, 2'b01, 1'b0, 16'h0);
        access(1'b0, 5'd2, 16'h0, 2'b00, 1'b1, 16'hFF34);
        access(1'b1, 5'd2, 16'hAB00, 2'b10, 1'b0, 16'h0);
        access(1'b0, 5'd2, 16'h0, 2'b00, 1'b1, 16'hAB34);
        access(1'b1, 5'd2, 16'h9999, 2'b00, 1'b0, 16'h0);
        access(1'b0, 5'd2, 16'h0, 2'b00, 1'b1, 16'hAB34);

        // Out of range and the last legal entry
        access(1'b1, 5'd3, 16'h3333, 2'b11, 1'b0, 16'h0);
        access(1'b1, 5'd21, 16'hBEEF, 2'b11, 1'b0, 16'h0);
        access(1'b0, 5'd21, 16'h0, 2'b00, 1'b1, 16'h0000);
        access(1'b0, 5'd3, 16'h0, 2'b00, 1'b1, 16'h3333);
        access(1'b1, 5'(DEPTH - 1), 16'hC0DE, 2'b11, 1'b0, 16'h0);
        access(1'b1, 5'(DEPTH), 16'hDEAD, 2'b11, 1'b0, 16'h0);
        access(1'b0, 5'(DEPTH), 16'h0, 2'b00, 1'b1, 16'h0000);
        access(1'b0, 5'(DEPTH - 1), 16'h0, 2'b00, 1'b1, 16'hC0DE);
        access(1'b0, 5'd31, 16'h0, 2'b00, 1'b1, 16'h0000);

        // clr during traffic
        access(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 16'hA5A5);
        do_clr();
        access(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 16'h0000);
        access(1'b0, 5'(DEPTH - 1), 16'h0, 2'b00, 1'b1, 16'h0000);

        // Reset arriving mid-clear restarts from entry 0
        access(1'b1, 5'd5, 16'h5555, 2'b11, 1'b0, 16'h0);
        access(1'b0, 5'd5, 16'h0, 2'b00, 1'b1, 16'h5555);
        do_reset(2);
        repeat (9) @(negedge clk);
        do_reset(1);
        check_clear_len("rst_mid_clear", 1'b1);
        access(1'b0, 5'd5, 16'h0, 2'b00, 1'b1, 16'h0000);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_clr();
            end else if (r < 10) begin
                idle($urandom_range(1, 3));
            end else begin
                access(1'($urandom_range(0, 1)), 5'($urandom_range(0, DEPTH + 3)),
                       16'($urandom), 2'($urandom_range(0, 3)), 1'b0, 16'h0);
            end
        end

        idle(3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
